shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Purpose : two-requester round-robin arbiter guarding one shared WIDTH-bit register.
// Latency : one edge from a request sampled in IDLE to q/gnt/owner/wr_cnt updated.
// Backpres: no stalls; one write per two cycles, requests during ACK are ignored.
//
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   req[1:0]       - write requests from requester 0 and 1
//   wdata0/wdata1  - write data of each requester, sampled only on the granting edge
//   gnt[1:0]       - one-hot acknowledge, high for the single ACK cycle after a write
//   q              - shared register contents
//   owner          - requester index of the most recent write
//   wr_cnt         - completed writes, modulo 16
module shared_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] q,
    output logic             owner,
    output logic [3:0]       wr_cnt
);

    // One-hot-style encoding chosen so the ACK states map directly onto gnt bits;
    // gnt is then the state flop itself, i.e. a registered Moore output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK0 = 2'b01,
        ACK1 = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q;
    logic             owner_q;
    logic [3:0]       wr_cnt_q;
    logic             last_q;     // last-granted requester index
    logic             wr_en;
    logic             win;

    // A write happens only when sampled in IDLE with any request pending.
    assign wr_en = (state_q == IDLE) && (req != 2'b00);

    // Single requester wins outright; on a tie the one not granted last wins.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACK states always fall back to IDLE after one cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = win ? ACK1 : ACK0;
                end
            end
            ACK0:    state_d = IDLE;
            ACK1:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt = 2'b00;
        case (state_q)
            ACK0:    gnt = 2'b01;
            ACK1:    gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Shared register, owner, write counter and round-robin pointer.
    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= '0;
            owner_q  <= 1'b0;
            wr_cnt_q <= 4'h0;
            last_q   <= 1'b1;
        end else if (wr_en) begin
            q_q      <= win ? wdata1 : wdata0;
            owner_q  <= win;
            wr_cnt_q <= wr_cnt_q + 4'd1;
            last_q   <= win;
        end
    end

    assign q      = q_q;
    assign owner  = owner_q;
    assign wr_cnt = wr_cnt_q;

endmodule
